// File: rtl/led_disp_arbiter.sv
// led_disp_arbiter: frame-buffer controller for an 8-digit seven-segment display.
// Two client ports write digits into a shadow buffer through a round-robin
// arbiter. The shadow is copied into the front buffer only on a frame
// boundary, and only when a client has asked for it. Also generates the
// scan tick and scan position for the downstream scanner.
// Optional blink support is compiled in with `define LED_DISP_BLINK_EN.
module led_disp_arbiter #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [2:0]  a_idx,
    input  logic [3:0]  a_val,
    input  logic        a_commit,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [2:0]  b_idx,
    input  logic [3:0]  b_val,
    input  logic        b_commit,
    output logic        b_ack,
`ifdef LED_DISP_BLINK_EN
    input  logic [7:0]  blink_mask,
`endif
    output logic        scan_tick,
    output logic        frame_start,
    output logic [2:0]  scan_pos,
    output logic        commit_pending,
    output logic [31:0] digits,
    output logic [7:0]  digit_blank
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             scan_tick_q, scan_tick_d;
    logic             frame_start_q, frame_start_d;
    logic [2:0]       scan_pos_q, scan_pos_d;
    logic             a_ack_q, a_ack_d;
    logic             b_ack_q, b_ack_d;
    port_e            last_grant_q, last_grant_d;
    logic             pending_q, pending_d;
    logic [7:0][3:0]  shadow_q, shadow_d;
    logic [7:0][3:0]  front_q, front_d;

    logic             cnt_wrap;
    logic             swap_edge;
    logic             a_elig, b_elig;
    logic             a_win, b_win;
    logic             wr_en;
    logic [2:0]       wr_idx;
    logic [3:0]       wr_val;
    logic             wr_commit;

    // Next-state logic: prescaler/scan position, arbitration, shadow write and frame swap.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path (defaults
        // first), otherwise synthesis would infer latches.
        cnt_wrap      = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d         = cnt_wrap ? '0 : cnt_q + 1'b1;
        scan_tick_d   = cnt_wrap;
        scan_pos_d    = scan_pos_q + 3'(cnt_wrap);
        swap_edge     = cnt_wrap && (scan_pos_q == 3'd7);
        frame_start_d = swap_edge;

        // An ack that is currently high masks its port, giving one write per
        // two cycles per port while still allowing one write per cycle overall.
        a_elig = a_req && !a_ack_q;
        b_elig = b_req && !b_ack_q;
        a_win  = a_elig && (!b_elig || (last_grant_q == PORT_B));
        b_win  = b_elig && !a_win;

        a_ack_d      = a_win;
        b_ack_d      = b_win;
        last_grant_d = last_grant_q;
        if (a_elig && b_elig) begin
            last_grant_d = a_win ? PORT_A : PORT_B;
        end

        wr_en     = a_win || b_win;
        wr_idx    = a_win ? a_idx    : b_idx;
        wr_val    = a_win ? a_val    : b_val;
        wr_commit = a_win ? a_commit : b_commit;

        // The copy takes the shadow as it was before this edge's write, so a
        // write landing on the swap edge stays out of the front buffer.
        front_d = front_q;
        if (swap_edge && pending_q) begin
            front_d = shadow_q;
        end

        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_idx] = wr_val;
        end

        // A commit write on the swap edge re-arms the request for the next frame.
        pending_d = (pending_q && !swap_edge) || (wr_en && wr_commit);
    end

    // State registers; asynchronous reset returns everything to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            scan_tick_q   <= 1'b0;
            frame_start_q <= 1'b0;
            scan_pos_q    <= 3'd0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            last_grant_q  <= PORT_B;
            pending_q     <= 1'b0;
            // NOTE: both digit buffers are reset because the display must show
            // zeros after reset; they are small registers, not RAM macros.
            shadow_q      <= '0;
            front_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q         <= cnt_d;
            scan_tick_q   <= scan_tick_d;
            frame_start_q <= frame_start_d;
            scan_pos_q    <= scan_pos_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
            last_grant_q  <= last_grant_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            front_q       <= front_d;
        end
    end

    assign scan_tick      = scan_tick_q;
    assign frame_start    = frame_start_q;
    assign scan_pos       = scan_pos_q;
    assign a_ack          = a_ack_q;
    assign b_ack          = b_ack_q;
    assign commit_pending = pending_q;
    assign digits         = front_q;

`ifdef LED_DISP_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      blank_q, blank_d;

    // Blink phase: toggles every BLINK_FRAMES frames; blank mask refreshed on frame boundaries only.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        blank_d     = blank_q;
        if (swap_edge) begin
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            blank_d = phase_d ? blink_mask : 8'h00;
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            blank_q     <= 8'h00;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            blank_q     <= blank_d;
        end
    end

    assign digit_blank = blank_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES > 0);
    assign digit_blank      = 8'h00;
`endif

endmodule

// File: tb/tb_led_disp_arbiter.sv
// Testbench for led_disp_arbiter: scenario tasks drive the two client ports
// from per-port write queues and compare the DUT against a frame-level model.
module tb_led_disp_arbiter;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] val;
        logic       commit;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [2:0]  a_idx = '0, b_idx = '0;
    logic [3:0]  a_val = '0, b_val = '0;
    logic        a_commit = 1'b0, b_commit = 1'b0;
    logic        a_ack, b_ack;
    logic        scan_tick, frame_start, commit_pending;
    logic [2:0]  scan_pos;
    logic [31:0] digits;
    logic [7:0]  digit_blank;
`ifdef LED_DISP_BLINK_EN
    logic [7:0]  blink_mask = 8'h81;
`endif

    int total = 0;
    int bad   = 0;

    // Model state: digit arrays, scan counters, pending flag, acks, fairness.
    int   m_shadow[8];
    int   m_front[8];
    int   m_cnt, m_pos, m_fcnt;
    bit   m_tick, m_fs, m_pend, m_aack, m_back, m_last_b, m_phase;
    logic [7:0] m_blank;

    wr_t qa[$];
    wr_t qb[$];

    led_disp_arbiter #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_idx(a_idx), .a_val(a_val), .a_commit(a_commit), .a_ack(a_ack),
        .b_req(b_req), .b_idx(b_idx), .b_val(b_val), .b_commit(b_commit), .b_ack(b_ack),
`ifdef LED_DISP_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .scan_tick(scan_tick), .frame_start(frame_start), .scan_pos(scan_pos),
        .commit_pending(commit_pending), .digits(digits), .digit_blank(digit_blank)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_shadow[k] = 0;
            m_front[k]  = 0;
        end
        m_cnt = 0; m_pos = 0; m_fcnt = 0;
        m_tick = 0; m_fs = 0; m_pend = 0; m_aack = 0; m_back = 0;
        m_last_b = 1; m_phase = 0; m_blank = 8'h00;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        bit ea, eb, ga, gb, fse;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ea  = a_req && !m_aack;
        eb  = b_req && !m_back;
        ga  = ea && (!eb || m_last_b);
        gb  = eb && !ga;
        if (ea && eb) m_last_b = gb;
        fse = (m_cnt == SCAN_DIV - 1) && (m_pos == 7);
        if (fse && m_pend) begin
            m_front = m_shadow;
            m_pend  = 0;
        end
        if (ga) begin
            m_shadow[a_idx] = a_val;
            if (a_commit) m_pend = 1;
        end
        if (gb) begin
            m_shadow[b_idx] = b_val;
            if (b_commit) m_pend = 1;
        end
        m_aack = ga;
        m_back = gb;
`ifdef LED_DISP_BLINK_EN
        if (fse) begin
            m_fcnt++;
            if (m_fcnt == BLINK_FRAMES) begin
                m_fcnt  = 0;
                m_phase = !m_phase;
            end
            m_blank = m_phase ? blink_mask : 8'h00;
        end
`endif
        m_tick = (m_cnt == SCAN_DIV - 1);
        m_fs   = fse;
        if (m_tick) m_pos = (m_pos + 1) % 8;
        m_cnt = (m_cnt + 1) % SCAN_DIV;
    endtask

    function automatic logic [31:0] exp_digits();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'(m_front[k]);
        return r;
    endfunction

    // Requesters present the head of their queue and hold it until acked.
    task automatic present();
        if (qa.size() > 0) begin
            a_req = 1'b1; a_idx = qa[0].idx; a_val = qa[0].val; a_commit = qa[0].commit;
        end else begin
            a_req = 1'b0; a_commit = 1'b0;
        end
        if (qb.size() > 0) begin
            b_req = 1'b1; b_idx = qb[0].idx; b_val = qb[0].val; b_commit = qb[0].commit;
        end else begin
            b_req = 1'b0; b_commit = 1'b0;
        end
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        if (m_aack && qa.size() > 0) void'(qa.pop_front());
        if (m_back && qb.size() > 0) void'(qb.pop_front());
        present();
    endtask

    task automatic test_reset();
        model_reset();
        present();
        @(negedge clk);
        total++;
        if (digits !== 32'h0) begin bad++; $display("FAIL reset_digits: got %h want %h", digits, 32'h0); end
        total++;
        if ({scan_tick, frame_start, scan_pos} !== 5'b0) begin
            bad++; $display("FAIL reset_scan: got %b want %b", {scan_tick, frame_start, scan_pos}, 5'b0);
        end
        total++;
        if ({commit_pending, a_ack, b_ack, digit_blank} !== 11'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want %b", {commit_pending, a_ack, b_ack, digit_blank}, 11'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Idle scanning straight after reset release: tick every SCAN_DIV cycles.
    task automatic test_scan();
        for (int k = 1; k <= 40; k++) begin
            step();
            total++;
            if (scan_tick !== ((k % SCAN_DIV) == 0)) begin
                bad++; $display("FAIL scan_tick@%0d: got %b want %b", k, scan_tick, (k % SCAN_DIV) == 0);
            end
            total++;
            if (scan_pos !== 3'((k / SCAN_DIV) % 8)) begin
                bad++; $display("FAIL scan_pos@%0d: got %0d want %0d", k, scan_pos, (k / SCAN_DIV) % 8);
            end
            total++;
            if (frame_start !== ((k % (8 * SCAN_DIV)) == 0)) begin
                bad++; $display("FAIL frame_start@%0d: got %b want %b", k, frame_start, (k % (8 * SCAN_DIV)) == 0);
            end
            total++;
            if (digits !== 32'h0) begin bad++; $display("FAIL idle_digits@%0d: got %h want 0", k, digits); end
        end
    endtask

    task automatic test_commit();
        int n = 0;
        qa.push_back('{idx: 3'd3, val: 4'd5, commit: 1'b0});
        qa.push_back('{idx: 3'd0, val: 4'd9, commit: 1'b1});
        present();
        while ((qa.size() > 0 || m_pend) && n < 100) begin
            step();
            n++;
            total++;
            if (digits !== exp_digits()) begin bad++; $display("FAIL commit_digits: got %h want %h", digits, exp_digits()); end
            total++;
            if (a_ack !== m_aack) begin bad++; $display("FAIL commit_ack: got %b want %b", a_ack, m_aack); end
            total++;
            if (commit_pending !== m_pend) begin bad++; $display("FAIL commit_pend: got %b want %b", commit_pending, m_pend); end
        end
        total++;
        if (n >= 100) begin bad++; $display("FAIL commit_timeout: got %0d cycles want <100", n); end
        total++;
        if ({digits[15:12], digits[3:0]} !== 8'h59) begin
            bad++; $display("FAIL commit_front: got %h want 59", {digits[15:12], digits[3:0]});
        end
        total++;
        if ({frame_start, commit_pending} !== 2'b10) begin
            bad++; $display("FAIL commit_swap: got %b want 10", {frame_start, commit_pending});
        end
    endtask

    task automatic test_contention();
        int got[$];
        int n = 0;
        rst_n = 1'b0;
        model_reset();
        qa.delete(); qb.delete();
        for (int i = 0; i < 3; i++) begin
            qa.push_back('{idx: 3'd1, val: 4'd2, commit: 1'b0});
            qb.push_back('{idx: 3'd1, val: 4'd7, commit: (i == 2)});
        end
        present();
        @(negedge clk);
        rst_n = 1'b1;
        while (got.size() < 6 && n < 50) begin
            step();
            n++;
            total++;
            if ((a_ack & b_ack) !== 1'b0) begin bad++; $display("FAIL dual_ack: got %b%b want not both", a_ack, b_ack); end
            if (a_ack === 1'b1) got.push_back(0);
            if (b_ack === 1'b1) got.push_back(1);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= got.size() || got[i] != (i % 2)) begin
                bad++; $display("FAIL grant_order[%0d]: got %0d want %0d", i, (i < got.size()) ? got[i] : -1, i % 2);
            end
        end
        n = 0;
        while (m_pend && n < 100) begin step(); n++; end
        total++;
        if (digits[7:4] !== 4'd7) begin bad++; $display("FAIL contention_idx1: got %0d want 7", digits[7:4]); end
    endtask

    // Commit write granted on the very edge that performs the swap.
    task automatic test_swap_edge();
        int n = 0;
        qa.push_back('{idx: 3'd2, val: 4'd3, commit: 1'b1});
        present();
        while ((qa.size() > 0 || m_aack) && n < 20) begin step(); n++; end
        while (!(m_cnt == SCAN_DIV - 1 && m_pos == 7) && n < 100) begin step(); n++; end
        total++;
        if (commit_pending !== 1'b1 || n >= 100) begin
            bad++; $display("FAIL swap_setup: got pend=%b cycles=%0d want pend=1", commit_pending, n);
        end
        qb.push_back('{idx: 3'd5, val: 4'hE, commit: 1'b1});
        present();
        step();
        total++;
        if ({frame_start, commit_pending, b_ack} !== 3'b111) begin
            bad++; $display("FAIL swap_edge_ctrl: got %b want 111", {frame_start, commit_pending, b_ack});
        end
        total++;
        if ({digits[23:20], digits[11:8]} !== 8'h03) begin
            bad++; $display("FAIL swap_edge_front: got %h want 03", {digits[23:20], digits[11:8]});
        end
        n = 0;
        while (m_pend && n < 100) begin step(); n++; end
        total++;
        if ({frame_start, commit_pending, digits[23:20]} !== 6'b10_1110) begin
            bad++; $display("FAIL swap_next_frame: got %b want 101110", {frame_start, commit_pending, digits[23:20]});
        end
        total++;
        if (digits !== exp_digits()) begin bad++; $display("FAIL swap_digits: got %h want %h", digits, exp_digits()); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        qa.push_back('{idx: 3'd4, val: 4'd6, commit: 1'b1});
        present();
        while (!m_aack && n < 10) begin step(); n++; end
        total++;
        if ({commit_pending, a_ack} !== 2'b11) begin
            bad++; $display("FAIL pre_reset: got %b want 11", {commit_pending, a_ack});
        end
        rst_n = 1'b0;
        model_reset();
        qa.delete(); qb.delete();
        present();
        #1;
        total++;
        if (digits !== 32'h0) begin bad++; $display("FAIL midreset_digits: got %h want 0", digits); end
        total++;
        if ({commit_pending, a_ack, b_ack, scan_tick, scan_pos} !== 7'b0) begin
            bad++; $display("FAIL midreset_ctrl: got %b want 0", {commit_pending, a_ack, b_ack, scan_tick, scan_pos});
        end
        @(negedge clk);
        rst_n = 1'b1;
        qa.push_back('{idx: 3'd4, val: 4'd6, commit: 1'b0});
        present();
        n = 0;
        while (!m_fs && n < 100) begin step(); n++; end
        total++;
        if ({frame_start, commit_pending} !== 2'b10 || digits !== 32'h0) begin
            bad++; $display("FAIL no_swap_after_reset: got fs/pend=%b digits=%h want 10 / 0", {frame_start, commit_pending}, digits);
        end
    endtask

    task automatic test_random();
        wr_t w;
        for (int c = 0; c < 800; c++) begin
            if (qa.size() < 3 && $urandom_range(2, 0) == 0) begin
                w.idx = 3'($urandom_range(7, 0)); w.val = 4'($urandom_range(15, 0));
                w.commit = ($urandom_range(3, 0) == 0);
                qa.push_back(w);
            end
            if (qb.size() < 3 && $urandom_range(2, 0) == 0) begin
                w.idx = 3'($urandom_range(7, 0)); w.val = 4'($urandom_range(15, 0));
                w.commit = ($urandom_range(3, 0) == 0);
                qb.push_back(w);
            end
            present();
            step();
            total++;
            if (digits !== exp_digits()) begin bad++; $display("FAIL rnd_digits@%0d: got %h want %h", c, digits, exp_digits()); end
            total++;
            if ({a_ack, b_ack, commit_pending} !== {m_aack, m_back, m_pend}) begin
                bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", c, {a_ack, b_ack, commit_pending}, {m_aack, m_back, m_pend});
            end
            total++;
            if ({scan_tick, frame_start, scan_pos} !== {m_tick, m_fs, 3'(m_pos)}) begin
                bad++; $display("FAIL rnd_scan@%0d: got %b want %b", c, {scan_tick, frame_start, scan_pos}, {m_tick, m_fs, 3'(m_pos)});
            end
            total++;
            if (digit_blank !== m_blank) begin bad++; $display("FAIL rnd_blank@%0d: got %h want %h", c, digit_blank, m_blank); end
        end
    endtask

    // Blank pattern across frames from reset: off for BLINK_FRAMES frames, then mask.
    task automatic test_blink();
        int f = 0;
        int n = 0;
        logic [7:0] exp;
        rst_n = 1'b0;
        model_reset();
        qa.delete(); qb.delete();
        present();
        @(negedge clk);
        rst_n = 1'b1;
        while (f < 5 && n < 5 * 8 * SCAN_DIV + 40) begin
            step();
            n++;
            if (m_fs) f++;
`ifdef LED_DISP_BLINK_EN
            exp = (((f / BLINK_FRAMES) % 2) == 1) ? blink_mask : 8'h00;
`else
            exp = 8'h00;
`endif
            total++;
            if (digit_blank !== exp) begin bad++; $display("FAIL blink@frame%0d: got %h want %h", f, digit_blank, exp); end
        end
        total++;
        if (f < 5) begin bad++; $display("FAIL blink_timeout: got %0d frames want 5", f); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_commit();
        test_contention();
        test_swap_edge();
        test_reset_mid();
        test_random();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
